// File: rtl/cp0_ctrl.sv
// CP0 system-control registers: prescaled Count/Compare timer, Status/Cause/EPC/BadVAddr,
// MEM-stage exception entry and ERET, interrupt request and a write-through MFC0 read path.
module cp0_ctrl #(
  parameter int          COUNT_DIV = 1,
  parameter int          HW_INT_W  = 6,
  parameter logic [31:0] PRID      = 32'h004C_0102
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [4:0]          raddr_i,
  input  logic [31:0]         data_i,
  input  logic [HW_INT_W-1:0] int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                exc_bd_i,
  input  logic                exc_badv_we_i,
  input  logic [31:0]         exc_badvaddr_i,
  input  logic                eret_i,
  output logic [31:0]         data_o,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         badvaddr_o,
  output logic [31:0]         config_o,
  output logic [31:0]         prid_o,
  output logic                timer_int_o,
  output logic                int_req_o
);

  localparam logic [4:0]  A_BADV = 5'd8;
  localparam logic [4:0]  A_CNT  = 5'd9;
  localparam logic [4:0]  A_CMP  = 5'd11;
  localparam logic [4:0]  A_STS  = 5'd12;
  localparam logic [4:0]  A_CAU  = 5'd13;
  localparam logic [4:0]  A_EPC  = 5'd14;
  localparam logic [4:0]  A_PRID = 5'd15;
  localparam logic [4:0]  A_CFG  = 5'd16;

  localparam logic [7:0]  PRESC_MAX   = 8'(COUNT_DIV - 1);
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;

  logic [7:0]  presc;
  logic        wr;
  logic        wr_cnt, wr_cmp, wr_sts, wr_cau, wr_epc;
  logic [5:0]  hw_ip;
  logic [31:0] cause_wr_val;
  logic [31:0] status_nxt, cause_nxt;
  logic [31:0] reg_val;

  // A committing exception squashes the MTC0 in the same cycle.
  assign wr     = we_i & ~exc_valid_i;
  assign wr_cnt = wr && (waddr_i == A_CNT);
  assign wr_cmp = wr && (waddr_i == A_CMP);
  assign wr_sts = wr && (waddr_i == A_STS);
  assign wr_cau = wr && (waddr_i == A_CAU);
  assign wr_epc = wr && (waddr_i == A_EPC);

  assign cause_wr_val = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
  assign config_o     = CONFIG_VAL;
  assign prid_o       = PRID;

  always_comb begin
    hw_ip                 = '0;
    hw_ip[HW_INT_W-1:0]   = int_i;
  end

  always_comb begin
    status_nxt = status_o;
    if (wr_sts) status_nxt = data_i;
    if (exc_valid_i)  status_nxt[1] = 1'b1;
    else if (eret_i)  status_nxt[1] = 1'b0;
  end

  always_comb begin
    cause_nxt = cause_o;
    if (wr_cau) cause_nxt = cause_wr_val;
    cause_nxt[15:10] = hw_ip;
    cause_nxt[15]    = hw_ip[5] | timer_int_o;
    if (exc_valid_i) begin
      if (!status_o[1]) cause_nxt[31] = exc_bd_i;
      cause_nxt[6:2] = exc_code_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      count_o     <= '0;
      compare_o   <= '0;
      status_o    <= STATUS_RST;
      cause_o     <= '0;
      epc_o       <= '0;
      badvaddr_o  <= '0;
      timer_int_o <= 1'b0;
    end else begin
      if (wr_cnt) begin
        count_o <= data_i;
        presc   <= '0;
      end else if (presc == PRESC_MAX) begin
        count_o <= count_o + 32'd1;
        presc   <= '0;
      end else begin
        presc <= presc + 8'd1;
      end

      if (wr_cmp) compare_o <= data_i;

      // Compare write acknowledges the timer and beats a same-cycle match.
      if (wr_cmp)
        timer_int_o <= 1'b0;
      else if ((compare_o != 32'd0) && (count_o == compare_o))
        timer_int_o <= 1'b1;

      status_o <= status_nxt;
      cause_o  <= cause_nxt;

      if (exc_valid_i && !status_o[1])
        epc_o <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
      else if (wr_epc)
        epc_o <= data_i;

      if (exc_valid_i && exc_badv_we_i) badvaddr_o <= exc_badvaddr_i;
    end
  end

  assign int_req_o = status_o[0] & ~status_o[1] & (|(status_o[15:8] & cause_o[15:8]));

  always_comb begin
    case (raddr_i)
      A_BADV:  reg_val = badvaddr_o;
      A_CNT:   reg_val = count_o;
      A_CMP:   reg_val = compare_o;
      A_STS:   reg_val = status_o;
      A_CAU:   reg_val = cause_o;
      A_EPC:   reg_val = epc_o;
      A_PRID:  reg_val = PRID;
      A_CFG:   reg_val = CONFIG_VAL;
      default: reg_val = 32'd0;
    endcase
  end

  // Write-through: a same-cycle MTC0 to the read address is visible immediately.
  always_comb begin
    data_o = reg_val;
    if (wr && (waddr_i == raddr_i)) begin
      case (raddr_i)
        A_CNT, A_CMP, A_STS, A_EPC: data_o = data_i;
        A_CAU:                      data_o = cause_wr_val;
        default:                    data_o = reg_val;
      endcase
    end
    if (rst) data_o = 32'd0;
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl with COUNT_DIV=4: reset values, prescaled timer,
// interrupt request, exception/ERET priority, read bypass and Count wrap.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic        exc_badv_we_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, config_o, prid_o;
  logic        timer_int_o, int_req_o;

  int checks = 0;
  int passed = 0;

  cp0_ctrl #(.COUNT_DIV(4), .HW_INT_W(6), .PRID(32'h004C_0102)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
    .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_badv_we_i(exc_badv_we_i), .exc_badvaddr_i(exc_badvaddr_i),
    .eret_i(eret_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o), .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    raddr_i = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
    we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we_i = 0; waddr_i = 0; raddr_i = 0; data_i = 0; int_i = 0;
    exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_bd_i = 0; exc_badv_we_i = 0;
    exc_badvaddr_i = 0; eret_i = 0;

    tick(); tick();
    rd(5'd15, 32'h0, "data_o_in_reset");
    rst = 1'b0;
    rd(5'd15, 32'h004C_0102, "rst_prid");
    rd(5'd16, 32'h0000_8000, "rst_config");
    rd(5'd12, 32'h1000_0000, "rst_status");
    rd(5'd3,  32'h0, "unmapped");
    chk("rst_count", count_o, 32'h0);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_timer_int", {31'd0, timer_int_o}, 32'h0);
    chk("rst_int_req", {31'd0, int_req_o}, 32'h0);

    // Count cleared with prescaler, then Compare=5: Count hits 5 after 20 edges
    mtc0(5'd9, 32'd0);
    chk("count_loaded", count_o, 32'd0);
    mtc0(5'd11, 32'd5);
    chk("compare_loaded", compare_o, 32'd5);
    repeat (18) tick();
    chk("count_19", count_o, 32'd4);
    tick();
    chk("count_20", count_o, 32'd5);
    chk("timer_not_yet", {31'd0, timer_int_o}, 32'h0);
    tick();
    chk("timer_set", {31'd0, timer_int_o}, 32'h1);
    chk("cause15_lag", {31'd0, cause_o[15]}, 32'h0);
    tick();
    chk("cause15_set", {31'd0, cause_o[15]}, 32'h1);
    chk("timer_sticky", {31'd0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd5);
    chk("timer_clear_wins", {31'd0, timer_int_o}, 32'h0);
    mtc0(5'd11, 32'd0);
    chk("timer_stays_clear", {31'd0, timer_int_o}, 32'h0);

    // Interrupt request from IP2 with IE=1, IM2=1
    mtc0(5'd12, 32'h1000_0401);
    chk("int_req_idle", {31'd0, int_req_o}, 32'h0);
    int_i = 6'b000001;
    #1;
    chk("ip2_lag", {31'd0, cause_o[10]}, 32'h0);
    chk("int_req_lag", {31'd0, int_req_o}, 32'h0);
    tick();
    chk("ip2_set", {31'd0, cause_o[10]}, 32'h1);
    chk("int_req_set", {31'd0, int_req_o}, 32'h1);
    mtc0(5'd12, 32'h1000_0403);
    chk("int_req_exl", {31'd0, int_req_o}, 32'h0);
    int_i = 6'b0;
    mtc0(5'd12, 32'h1000_0000);
    chk("status_written", status_o, 32'h1000_0000);

    // Exception in delay slot while EXL=0
    exc_valid_i = 1; exc_pc_i = 32'h0000_0104; exc_bd_i = 1; exc_code_i = 5'd8;
    exc_badv_we_i = 1; exc_badvaddr_i = 32'hDEAD_BEEF;
    tick();
    exc_valid_i = 0; exc_badv_we_i = 0;
    chk("exc_epc", epc_o, 32'h0000_0100);
    chk("exc_cause", cause_o, 32'h8000_0020);
    chk("exc_status", status_o, 32'h1000_0002);
    chk("exc_badvaddr", badvaddr_o, 32'hDEAD_BEEF);

    // Nested exception with a squashed MTC0 Status and an ignored ERET
    exc_valid_i = 1; exc_pc_i = 32'h0000_0200; exc_bd_i = 0; exc_code_i = 5'd4;
    we_i = 1; waddr_i = 5'd12; data_i = 32'h0; eret_i = 1;
    tick();
    exc_valid_i = 0; we_i = 0; eret_i = 0;
    chk("nest_epc", epc_o, 32'h0000_0100);
    chk("nest_cause", cause_o, 32'h8000_0010);
    chk("nest_status", status_o, 32'h1000_0002);
    chk("nest_badvaddr", badvaddr_o, 32'hDEAD_BEEF);
    eret_i = 1;
    tick();
    eret_i = 0;
    chk("eret_status", status_o, 32'h1000_0000);

    // Write-through read of Cause merges with live IP and ExcCode
    int_i = 6'b000010;
    tick();
    chk("ip3_set", cause_o, 32'h8000_0810);
    we_i = 1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF;
    rd(5'd13, 32'h80C0_0B10, "bypass_cause");
    rd(5'd12, 32'h1000_0000, "no_bypass_other");
    tick();
    we_i = 0;
    chk("cause_after_write", cause_o, 32'h80C0_0B10);
    we_i = 1; waddr_i = 5'd15; data_i = 32'h0;
    rd(5'd15, 32'h004C_0102, "ro_prid_bypass");
    tick();
    we_i = 0;
    chk("ro_prid_kept", prid_o, 32'h004C_0102);
    rd(5'd8, 32'hDEAD_BEEF, "read_badvaddr");
    rd(5'd14, 32'h0000_0100, "read_epc");

    // Count wraps to zero
    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("count_max", count_o, 32'hFFFF_FFFF);
    repeat (4) tick();
    chk("count_wrap", count_o, 32'h0);

    // Mid-run reset with a pending timer
    mtc0(5'd11, 32'd2);
    mtc0(5'd9, 32'd2);
    tick();
    chk("timer_before_rst", {31'd0, timer_int_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_timer", {31'd0, timer_int_o}, 32'h0);
    chk("mid_rst_count", count_o, 32'h0);
    chk("mid_rst_compare", compare_o, 32'h0);
    chk("mid_rst_status", status_o, 32'h1000_0000);
    chk("mid_rst_epc", epc_o, 32'h0);
    chk("mid_rst_badvaddr", badvaddr_o, 32'h0);
    repeat (3) tick();
    chk("mid_rst_presc", count_o, 32'h0);
    tick();
    chk("mid_rst_presc_wrap", count_o, 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
